// File: rtl/ac_store_ctrl.sv
// ac_store_ctrl: writes a captured accumulator word to memory over a 4-phase mem_we/mem_ack handshake.
// Optional REQ-phase timeout abort is compiled in when AC_STORE_TIMEOUT_EN is defined.
module ac_store_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] ac_in,
   input  logic [11:0] addr,
   input  logic        store,
   input  logic        mem_ack,
   output logic        mem_we,
   output logic [11:0] mem_addr,
   output logic [15:0] mem_data,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_RELEASE = 2'd2,
      S_FIN     = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        mem_we_q, mem_we_d;
   logic [11:0] mem_addr_q, mem_addr_d;
   logic [15:0] mem_data_q, mem_data_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        tmo_hit;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("ac_store_ctrl: TIMEOUT_CYCLES must be in 1..255");
   end

`ifdef AC_STORE_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] cnt_q, cnt_d;

   // Counter is held at zero outside REQ, so it is clear on every REQ entry.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q != S_REQ) begin
         cnt_d = 8'd0;
      end else if (!mem_ack) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // An ack in the final cycle takes priority over the abort.
   assign tmo_hit = (state_q == S_REQ) && !mem_ack && (cnt_q == TIMEOUT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      mem_we_d   = mem_we_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (store) begin
               mem_data_d = ac_in;
               mem_addr_d = addr;
               mem_we_d   = 1'b1;
               state_d    = S_REQ;
            end
         end
         S_REQ: begin
            if (mem_ack) begin
               mem_we_d = 1'b0;
               state_d  = S_RELEASE;
            end else if (tmo_hit) begin
               mem_we_d = 1'b0;
               err_d    = 1'b1;
               state_d  = S_IDLE;
            end
         end
         S_RELEASE: begin
            if (!mem_ack) begin
               done_d  = 1'b1;
               state_d = S_FIN;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            mem_we_d = 1'b0;
            state_d  = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         mem_we_q   <= 1'b0;
         mem_addr_q <= 12'd0;
         mem_data_q <= 16'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign mem_we   = mem_we_q;
   assign mem_addr = mem_addr_q;
   assign mem_data = mem_data_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_ac_store_ctrl.sv
// Randomized bench for ac_store_ctrl: transfer-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_ac_store_ctrl;
   localparam int TO = 4;
`ifdef AC_STORE_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] ac_in = 16'd0;
   logic [11:0] addr = 12'd0;
   logic        store = 1'b0;
   logic        mem_ack = 1'b0;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [15:0] mem_data;
   logic        busy;
   logic        done;
   logic        err;

   ac_store_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .ac_in(ac_in), .addr(addr), .store(store),
      .mem_ack(mem_ack), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: one transfer in flight, described by its handshake phase.
   // phase 0 none, 1 waiting for ack, 2 waiting for ack release, 3 completion cycle.
   int          phase = 0;
   int          waited = 0;
   logic        e_we = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
   logic [15:0] e_data = 16'd0;
   logic [11:0] e_addr = 12'd0;

   always @(posedge clk) begin
      if (reset) begin
         phase = 0; waited = 0;
         e_we = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
         e_data = 16'd0; e_addr = 12'd0;
      end else begin
         e_done = 1'b0;
         e_err  = 1'b0;
         if (phase == 0) begin
            if (store) begin
               e_data = ac_in; e_addr = addr; e_we = 1'b1; phase = 1; waited = 0;
            end
         end else if (phase == 1) begin
            if (mem_ack) begin
               e_we = 1'b0; phase = 2;
            end else begin
               waited = waited + 1;
               if (TO_EN && waited == TO) begin
                  e_we = 1'b0; e_err = 1'b1; phase = 0;
               end
            end
         end else if (phase == 2) begin
            if (!mem_ack) begin
               e_done = 1'b1; phase = 3;
            end
         end else begin
            phase = 0;
         end
         e_busy = (phase != 0);
      end
   end

   bit cmp_en = 1'b0;
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cyc_mem_we", 32'(mem_we), 32'(e_we));
         chk("cyc_mem_addr", 32'(mem_addr), 32'(e_addr));
         chk("cyc_mem_data", 32'(mem_data), 32'(e_data));
         chk("cyc_busy", 32'(busy), 32'(e_busy));
         chk("cyc_done", 32'(done), 32'(e_done));
         chk("cyc_err", 32'(err), 32'(e_err));
      end
   end

   // Memory responder: raises ack up_d cycles after seeing mem_we, drops it dn_d cycles after mem_we falls.
   bit auto_ack = 1'b0;
   int up_d = 1, dn_d = 1, wait_c = 0;

   task automatic tick();
      @(posedge clk);
      #1;
      if (auto_ack) begin
         if (!mem_ack && mem_we) begin
            if (wait_c >= up_d) begin mem_ack = 1'b1; wait_c = 0; end
            else wait_c = wait_c + 1;
         end else if (mem_ack && !mem_we) begin
            if (wait_c >= dn_d) begin mem_ack = 1'b0; wait_c = 0; end
            else wait_c = wait_c + 1;
         end else begin
            wait_c = 0;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, n_done, n_cap, we_cnt;
      bit got_done, got_err, prev_we, any_bad;

      reset = 1'b1;
      tick(); tick();
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_mem_data", 32'(mem_data), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      reset = 1'b0;
      cmp_en = 1'b1;
      tick();

      // Basic store with one-cycle ack/release; inputs change after capture.
      auto_ack = 1'b1; up_d = 1; dn_d = 1; wait_c = 0;
      ac_in = 16'hA5C3; addr = 12'h07F; store = 1'b1;
      tick();
      store = 1'b0; ac_in = 16'h0001; addr = 12'hFFF;
      lat = 0; got_done = 1'b0;
      for (int n = 1; n <= 20 && !got_done; n++) begin
         if (mem_we) begin
            chk("t1_data_while_we", 32'(mem_data), 32'h0000A5C3);
            chk("t1_addr_while_we", 32'(mem_addr), 32'h0000007F);
         end
         tick();
         if (done) begin got_done = 1'b1; lat = n; end
      end
      chk("t1_latency", 32'(lat), 32'd4);
      chk("t1_data_at_done", 32'(mem_data), 32'h0000A5C3);
      tick();
      chk("t1_done_one_cycle", 32'(done), 32'd0);
      chk("t1_idle_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 4; i++) tick();

      // store held high with immediate ack/release: 4-cycle back-to-back transfers.
      up_d = 0; dn_d = 0; wait_c = 0;
      n_done = 0; n_cap = 0; prev_we = 1'b0;
      store = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         ac_in = 16'($urandom); addr = 12'($urandom);
         if (done) n_done++;
         if (mem_we && !prev_we) n_cap++;
         prev_we = mem_we;
      end
      store = 1'b0;
      chk("t2_done_count", 32'(n_done), 32'd10);
      chk("t2_capture_count", 32'(n_cap), 32'd10);
      for (int i = 0; i < 6; i++) tick();

      // Reset while waiting for ack release.
      up_d = 1; dn_d = 3; wait_c = 0;
      store = 1'b1;
      tick();
      store = 1'b0;
      got_done = 1'b0;
      for (int n = 0; n < 20 && !got_done; n++) begin
         tick();
         if (!mem_we && busy) got_done = 1'b1;
      end
      chk("t3_reached_release", 32'(got_done), 32'd1);
      reset = 1'b1; store = 1'b1;
      tick();
      reset = 1'b0; store = 1'b0;
      chk("t3_mem_we", 32'(mem_we), 32'd0);
      chk("t3_busy", 32'(busy), 32'd0);
      chk("t3_done", 32'(done), 32'd0);
      chk("t3_err", 32'(err), 32'd0);
      for (int i = 0; i < 8; i++) tick();

`ifdef AC_STORE_TIMEOUT_EN
      // Ack never comes: abort after TO cycles of mem_we.
      up_d = 1000; dn_d = 0; wait_c = 0;
      store = 1'b1;
      tick();
      store = 1'b0;
      we_cnt = 0; got_err = 1'b0; got_done = 1'b0;
      for (int n = 0; n < 20 && !got_err; n++) begin
         if (mem_we) we_cnt++;
         tick();
         if (done) got_done = 1'b1;
         if (err) begin
            got_err = 1'b1;
            chk("t4_busy_at_err", 32'(busy), 32'd0);
            chk("t4_we_at_err", 32'(mem_we), 32'd0);
         end
      end
      chk("t4_err_seen", 32'(got_err), 32'd1);
      chk("t4_no_done", 32'(got_done), 32'd0);
      chk("t4_we_cycles", 32'(we_cnt), 32'd4);
      tick();
      chk("t4_err_one_cycle", 32'(err), 32'd0);
      // Ack arrives in the cycle the count would expire: normal completion.
      up_d = 3; dn_d = 1; wait_c = 0;
      store = 1'b1;
      tick();
      store = 1'b0;
      got_err = 1'b0; got_done = 1'b0;
      for (int n = 0; n < 20; n++) begin
         tick();
         if (done) got_done = 1'b1;
         if (err) got_err = 1'b1;
      end
      chk("t5_done_seen", 32'(got_done), 32'd1);
      chk("t5_no_err", 32'(got_err), 32'd0);
`else
      // No timeout: mem_we must be held while ack is withheld.
      auto_ack = 1'b0; mem_ack = 1'b0;
      store = 1'b1;
      tick();
      store = 1'b0;
      any_bad = 1'b0;
      for (int n = 0; n < 1000; n++) begin
         tick();
         if (!mem_we || err) any_bad = 1'b1;
      end
      chk("t4_we_held", 32'(mem_we), 32'd1);
      chk("t4_no_drop_or_err", 32'(any_bad), 32'd0);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      tick();
      chk("t4_late_done", 32'(done), 32'd1);
      for (int i = 0; i < 3; i++) tick();
      auto_ack = 1'b1; wait_c = 0;
`endif

      // Randomized traffic with ack noise in idle and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         store = ($urandom_range(0, 2) == 0);
         ac_in = 16'($urandom);
         addr = 12'($urandom);
         reset = ($urandom_range(0, 99) == 0);
         if (!busy && !mem_ack) begin
            up_d = $urandom_range(0, 6);
            dn_d = $urandom_range(0, 3);
         end
         if (!busy && !mem_we && $urandom_range(0, 9) == 0) mem_ack = ~mem_ack;
         tick();
      end
      reset = 1'b0; store = 1'b0;
      for (int i = 0; i < 20; i++) tick();

      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ac_store_ctrl.md
AC_STORE_CTRL -- requirements
Module: ac_store_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, number of REQ-state cycles without mem_ack before abort (range 1..255).
REQ-002 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: reset  input  1  reset is synchronous and active-high.
REQ-004 Port: ac_in  input  16  accumulator value to be stored.
REQ-005 Port: addr  input  12  target memory word address.
REQ-006 Port: store  input  1  start request, sampled each edge.
REQ-007 Port: mem_ack  input  1  memory write acknowledge (4-phase handshake).
REQ-008 Port: mem_we  output  1  memory write request.
REQ-009 Port: mem_addr  output  12  registered write address.
REQ-010 Port: mem_data  output  16  registered write data.
REQ-011 Port: busy  output  1  high in any state other than IDLE.
REQ-012 Port: done  output  1  one-cycle pulse on completed store.
REQ-013 Port: err  output  1  one-cycle pulse on timeout abort.

Function
REQ-014 States SHALL be IDLE, REQ, RELEASE, FIN; all outputs registered.
REQ-015 IDLE with store=1: capture ac_in->mem_data, addr->mem_addr, assert mem_we, go REQ, busy=1 from the next cycle.
REQ-016 IDLE with store=0: hold state; mem_data/mem_addr retain last captured values.
REQ-017 REQ: mem_we held high, mem_data/mem_addr stable; on mem_ack=1 deassert mem_we and go RELEASE.
REQ-018 RELEASE: mem_we=0; wait for mem_ack=0, then go FIN.
REQ-019 FIN: done=1 for exactly this one cycle, then IDLE; busy=1 in FIN.
REQ-020 Latency with ack returned one cycle after mem_we and dropped one cycle after mem_we falls: store edge to done pulse = 4 cycles.
REQ-021 store asserted while busy SHALL be ignored (no queueing); store=1 in the IDLE cycle following FIN starts a new transfer.
REQ-022 mem_ack=1 while in IDLE SHALL be ignored; a transfer started with mem_ack already high still requires mem_ack sampled high in REQ (first REQ cycle qualifies).
REQ-023 ac_in/addr changes after capture SHALL NOT affect mem_data/mem_addr until next capture.

Reset
REQ-024 reset=1 at a clock edge forces IDLE, mem_we=0, done=0, err=0, busy=0, mem_addr=0, mem_data=0, timeout counter=0.
REQ-025 reset mid-transfer (any state) aborts without done or err pulse; reset dominates store.

Configuration
REQ-026 Macro AC_STORE_TIMEOUT_EN defined: 8-bit counter clears on REQ entry, increments each REQ cycle with mem_ack=0; on reaching TIMEOUT_CYCLES, drop mem_we, pulse err one cycle, return IDLE directly (no done).
REQ-027 Macro AC_STORE_TIMEOUT_EN undefined: no counter logic, err tied 0, REQ waits indefinitely.
REQ-028 mem_ack arriving in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win (normal completion).

Verification
REQ-029 reset, ac_in=16'hA5C3, addr=12'h07F, store pulse, ack 1 cycle after mem_we, drop 1 cycle later -> mem_data=A5C3, mem_addr=07F while mem_we high, done pulse 4 cycles after store.
REQ-030 store held high continuously, immediate ack/drop -> back-to-back transfers, one done per transfer, no store captured while busy.
REQ-031 ac_in changed to 16'h0001 while in REQ -> mem_data stays A5C3 until done.
REQ-032 reset asserted in RELEASE -> next cycle IDLE, mem_we=0, no done, no err.
REQ-033 AC_STORE_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, mem_ack never asserted -> mem_we high 4 cycles, err pulse, busy=0 next cycle; ack on cycle 4 -> done path, no err.
REQ-034 AC_STORE_TIMEOUT_EN undefined, no ack for 1000 cycles -> mem_we stays high, err stays 0.
